// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the two-port memory bus arbiter: state encoding,
// port indices and read/write encoding.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_ACK  = 2'd3;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side handshake plus the multiplexed AD bus of the memory arbiter.
// The arbiter uses the slave modport; requesters and memory use master.
interface mem_bus_arbiter_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        req;
    logic [1:0]        rw;
    logic [DATA_W-1:0] addr0;
    logic [DATA_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        ack;
    logic [1:0]        grant;
    logic [DATA_W-1:0] rdata;
    logic              ALE;
    logic              En;
    logic              Rw;
    logic [DATA_W-1:0] ad_out;
    logic              ad_oe;
    logic [DATA_W-1:0] ad_in;

    modport master (
        output req, rw, addr0, addr1, wdata0, wdata1, ad_in,
        input  ack, grant, rdata, ALE, En, Rw, ad_out, ad_oe
    );

    modport slave (
        input  req, rw, addr0, addr1, wdata0, wdata1, ad_in,
        output ack, grant, rdata, ALE, En, Rw, ad_out, ad_oe
    );

endinterface

// File: rtl/mem_bus_arbiter_pick.sv
// Two-way request picker returning a one-hot winner. With MEM_ARB_RR_EN
// defined a tie goes to the port not served last; otherwise port 0 wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic       last_port,
`endif
    input  logic [1:0] req,
    output logic [1:0] win
);

    always_comb begin
        win = req;
        if (req == 2'b11) begin
`ifdef MEM_ARB_RR_EN
            win = port_onehot(!last_port);
`else
            win = port_onehot(PORT_CPU);
`endif
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter and ALE/En bus-cycle sequencer for the multiplexed memory
// bus. Define MEM_ARB_RR_EN for round-robin; default is fixed port-0 priority.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.slave  bus
);

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [2:0]        wait_q, wait_d;
    logic              port_q, port_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        win;

`ifdef MEM_ARB_RR_EN
    // Reset to the loader port so the CPU wins the first tie.
    logic              last_q, last_d;

    mem_arb_pick u_pick (
        .last_port (last_q),
        .req       (bus.req),
        .win       (win)
    );
`else
    mem_arb_pick u_pick (
        .req       (bus.req),
        .win       (win)
    );
`endif

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        port_d  = port_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef MEM_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    port_d  = win[1];
                    rw_d    = bus.rw[win[1]];
                    addr_d  = win[1] ? bus.addr1 : bus.addr0;
                    wdata_d = win[1] ? bus.wdata1 : bus.wdata0;
`ifdef MEM_ARB_RR_EN
                    last_d  = win[1];
`endif
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                wait_d  = WAIT_INIT;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (wait_q == 3'd0) begin
                    if (rw_q == RW_READ) begin
                        rdata_d = bus.ad_in;
                    end
                    state_d = ST_ACK;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wait_q  <= 3'd0;
            port_q  <= PORT_CPU;
            rw_q    <= RW_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_q  <= PORT_LDR;
`endif
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            port_q  <= port_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    // Bus outputs decode only flopped state, so req never reaches the pins.
    always_comb begin
        bus.ack    = (state_q == ST_ACK) ? port_onehot(port_q) : 2'b00;
        bus.grant  = (state_q != ST_IDLE) ? port_onehot(port_q) : 2'b00;
        bus.rdata  = rdata_q;
        bus.ALE    = (state_q == ST_ADDR);
        bus.En     = (state_q == ST_DATA);
        bus.Rw     = RW_READ;
        bus.ad_out = '0;
        bus.ad_oe  = 1'b0;
        if (state_q == ST_ADDR) begin
            bus.Rw     = rw_q;
            bus.ad_out = addr_q;
            bus.ad_oe  = 1'b1;
        end else if (state_q == ST_DATA) begin
            bus.Rw = rw_q;
            if (rw_q == RW_WRITE) begin
                bus.ad_out = wdata_q;
                bus.ad_oe  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table of single transactions plus
// hand-written arbitration, reset, hold and zero-wait sequences.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.DATA_W(8)) bus ();
    mem_bus_arbiter_if #(.DATA_W(8)) bus0 ();

    mem_bus_arbiter #(.DATA_W(8), .WAIT_CYCLES(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    mem_bus_arbiter #(.DATA_W(8), .WAIT_CYCLES(0)) dut_w0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic       port;
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] ad_in;
        logic [1:0] exp_grant;
        logic       exp_data_oe;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[4];

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    // The idle port is loaded with complementary values to expose mux errors.
    task automatic applyStimulus(input vec_t v);
        bus.rw[v.port]      = v.rw;
        bus.rw[!v.port]     = !v.rw;
        bus.addr0           = v.port ? ~v.addr  : v.addr;
        bus.addr1           = v.port ? v.addr   : ~v.addr;
        bus.wdata0          = v.port ? ~v.wdata : v.wdata;
        bus.wdata1          = v.port ? v.wdata  : ~v.wdata;
        bus.ad_in           = v.ad_in;
        bus.req             = v.port ? 2'b10 : 2'b01;
    endtask

    task automatic runVector(input vec_t v, input int idx);
        applyStimulus(v);
        next_cycle();
        checkOutput($sformatf("v%0d addr ALE", idx), 8'(bus.ALE), 8'd1);
        checkOutput($sformatf("v%0d addr En", idx), 8'(bus.En), 8'd0);
        checkOutput($sformatf("v%0d addr ad_out", idx), bus.ad_out, v.addr);
        checkOutput($sformatf("v%0d addr ad_oe", idx), 8'(bus.ad_oe), 8'd1);
        checkOutput($sformatf("v%0d addr grant", idx), 8'(bus.grant), 8'(v.exp_grant));
        checkOutput($sformatf("v%0d addr Rw", idx), 8'(bus.Rw), 8'(v.rw));
        next_cycle();
        checkOutput($sformatf("v%0d data1 ALE", idx), 8'(bus.ALE), 8'd0);
        checkOutput($sformatf("v%0d data1 En", idx), 8'(bus.En), 8'd1);
        checkOutput($sformatf("v%0d data1 ad_oe", idx), 8'(bus.ad_oe), 8'(v.exp_data_oe));
        checkOutput($sformatf("v%0d data1 Rw", idx), 8'(bus.Rw), 8'(v.rw));
        if (v.exp_data_oe) begin
            checkOutput($sformatf("v%0d data1 ad_out", idx), bus.ad_out, v.wdata);
        end
        next_cycle();
        checkOutput($sformatf("v%0d data2 En", idx), 8'(bus.En), 8'd1);
        checkOutput($sformatf("v%0d data2 ack", idx), 8'(bus.ack), 8'd0);
        next_cycle();
        checkOutput($sformatf("v%0d ack ack", idx), 8'(bus.ack), 8'(v.exp_grant));
        checkOutput($sformatf("v%0d ack En", idx), 8'(bus.En), 8'd0);
        checkOutput($sformatf("v%0d ack ad_oe", idx), 8'(bus.ad_oe), 8'd0);
        checkOutput($sformatf("v%0d ack rdata", idx), bus.rdata, v.exp_rdata);
        bus.req = 2'b00;
        next_cycle();
        checkOutput($sformatf("v%0d idle ack", idx), 8'(bus.ack), 8'd0);
        checkOutput($sformatf("v%0d idle grant", idx), 8'(bus.grant), 8'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] order[4];
        logic [1:0] exp_order[4];
        int         seen;
        int         acks;

        //               port  rw    addr   wdata  ad_in  grant  oe    rdata
        vecs[0] = '{1'b0, 1'b1, 8'h3C, 8'h00, 8'hA5, 2'b01, 1'b0, 8'hA5};
        vecs[1] = '{1'b1, 1'b0, 8'h10, 8'h7E, 8'h33, 2'b10, 1'b1, 8'hA5};
        vecs[2] = '{1'b1, 1'b1, 8'h81, 8'h00, 8'h0F, 2'b10, 1'b0, 8'h0F};
        vecs[3] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h99, 2'b01, 1'b1, 8'h0F};

`ifdef MEM_ARB_RR_EN
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

        bus.req = 2'b00;  bus.rw = 2'b11;
        bus.addr0 = 8'h00; bus.addr1 = 8'h00;
        bus.wdata0 = 8'h00; bus.wdata1 = 8'h00; bus.ad_in = 8'h00;
        bus0.req = 2'b00; bus0.rw = 2'b11;
        bus0.addr0 = 8'h00; bus0.addr1 = 8'h00;
        bus0.wdata0 = 8'h00; bus0.wdata1 = 8'h00; bus0.ad_in = 8'h00;

        rst = 1'b1;
        next_cycle();
        checkOutput("reset ack", 8'(bus.ack), 8'd0);
        checkOutput("reset grant", 8'(bus.grant), 8'd0);
        checkOutput("reset rdata", bus.rdata, 8'h00);
        checkOutput("reset ALE", 8'(bus.ALE), 8'd0);
        checkOutput("reset En", 8'(bus.En), 8'd0);
        checkOutput("reset Rw", 8'(bus.Rw), 8'd1);
        checkOutput("reset ad_out", bus.ad_out, 8'h00);
        checkOutput("reset ad_oe", 8'(bus.ad_oe), 8'd0);
        rst = 1'b0;
        next_cycle();

        for (int i = 0; i < 4; i++) begin
            runVector(vecs[i], i);
        end

        // Both ports requesting continuously from a fresh reset.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        bus.rw = 2'b11; bus.addr0 = 8'h01; bus.addr1 = 8'h02; bus.ad_in = 8'h6B;
        bus.req = 2'b11;
        order = '{2'b00, 2'b00, 2'b00, 2'b00};
        seen = 0;
        for (int c = 0; c < 60 && seen < 4; c++) begin
            next_cycle();
            if (bus.ack != 2'b00) begin
                order[seen] = bus.grant;
                seen++;
                if (seen == 4) bus.req = 2'b00;
            end
        end
        bus.req = 2'b00;
        checkOutput("alt ack count", 8'(seen), 8'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("alt grant %0d", i), 8'(order[i]), 8'(exp_order[i]));
        end
        next_cycle();

        // Reset lands in the data phase of a port-0 write.
        bus.rw = 2'b10; bus.addr0 = 8'h30; bus.wdata0 = 8'hC3;
        bus.req = 2'b01;
        next_cycle();
        next_cycle();
        checkOutput("mid pre En", 8'(bus.En), 8'd1);
        checkOutput("mid pre ad_out", bus.ad_out, 8'hC3);
        rst = 1'b1;
        #1;
        checkOutput("mid rst En", 8'(bus.En), 8'd0);
        checkOutput("mid rst ad_oe", 8'(bus.ad_oe), 8'd0);
        checkOutput("mid rst grant", 8'(bus.grant), 8'd0);
        checkOutput("mid rst rdata", bus.rdata, 8'h00);
        checkOutput("mid rst Rw", 8'(bus.Rw), 8'd1);
        bus.req = 2'b00;
        next_cycle();
        rst = 1'b0;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            if (bus.ack != 2'b00) acks++;
        end
        checkOutput("mid no ack", 8'(acks), 8'd0);
        bus.rw = 2'b11;
        bus.req = 2'b11;
        next_cycle();
        checkOutput("post rst grant", 8'(bus.grant), 8'd1);
        next_cycle();
        next_cycle();
        next_cycle();
        checkOutput("post rst ack", 8'(bus.ack), 8'd1);
        bus.req = 2'b00;
        next_cycle();

        // Request fields change during the data phase and must be ignored.
        bus.rw = 2'b10; bus.addr0 = 8'h20; bus.wdata0 = 8'h99;
        bus.req = 2'b01;
        next_cycle();
        checkOutput("hold addr", bus.ad_out, 8'h20);
        next_cycle();
        checkOutput("hold data1", bus.ad_out, 8'h99);
        bus.addr0 = 8'h55; bus.wdata0 = 8'h11; bus.rw = 2'b11;
        next_cycle();
        checkOutput("hold data2", bus.ad_out, 8'h99);
        checkOutput("hold Rw", 8'(bus.Rw), 8'd0);
        checkOutput("hold ad_oe", 8'(bus.ad_oe), 8'd1);
        next_cycle();
        checkOutput("hold ack", 8'(bus.ack), 8'd1);
        bus.req = 2'b00;
        next_cycle();

        // Zero-wait read on the second instance.
        bus0.rw = 2'b11; bus0.addr0 = 8'h44; bus0.addr1 = 8'hBB; bus0.ad_in = 8'h5A;
        bus0.req = 2'b01;
        next_cycle();
        checkOutput("w0 ALE", 8'(bus0.ALE), 8'd1);
        checkOutput("w0 ad_out", bus0.ad_out, 8'h44);
        next_cycle();
        checkOutput("w0 data En", 8'(bus0.En), 8'd1);
        checkOutput("w0 data ack", 8'(bus0.ack), 8'd0);
        next_cycle();
        checkOutput("w0 ack", 8'(bus0.ack), 8'd1);
        checkOutput("w0 ack En", 8'(bus0.En), 8'd0);
        checkOutput("w0 rdata", bus0.rdata, 8'h5A);
        bus0.req = 2'b00;
        next_cycle();
        checkOutput("w0 idle ack", 8'(bus0.ack), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and bus-cycle sequencer for the shared multiplexed address/data memory bus. It grants the bus to the CPU (port 0) or the program loader/debug port (port 1) and runs an ALE address phase followed by an En data phase with a fixed wait count. It returns read data and a one-cycle ack to the granted requester. It sits between the CPU core's memory strobes and the external memory/latch, so loader traffic can share memory without corrupting CPU cycles.

## Interface
- DATA_W, 8, address and data width (bus is multiplexed, so they are equal)
- WAIT_CYCLES, 1, extra data-phase cycles, range 0..7

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  2  per-port request, level; held until ack
- rw  in  2  per-port direction: 1 read, 0 write; stable while req high
- addr0, addr1  in  DATA_W  per-port address; stable while req high
- wdata0, wdata1  in  DATA_W  per-port write data; stable while req high
- ack  out  2  one-cycle pulse to the granted port at completion
- grant  out  2  one-hot owner; high from ADDR through ACK
- rdata  out  DATA_W  captured read data; valid when ack is high, held until the next read capture
- ALE  out  1  address latch enable
- En  out  1  memory enable
- Rw  out  1  bus direction: 1 read, 0 write
- ad_out  out  DATA_W  value driven onto the AD bus
- ad_oe  out  1  AD output enable
- ad_in  in  DATA_W  AD bus input, sampled for reads

## Operation
- States: IDLE, ADDR, DATA, ACK. A wait counter (3 bits) runs inside DATA.
- IDLE: if any req bit is high, choose a winner, latch its index, rw, addr and wdata, then go to ADDR. Otherwise stay in IDLE.
- ADDR (1 cycle): ALE=1, ad_out=addr, ad_oe=1, Rw=latched rw, En=0.
- DATA (1+WAIT_CYCLES cycles): En=1, ALE=0, Rw=latched rw.
  - Write: ad_out=wdata, ad_oe=1.
  - Read: ad_oe=0. ad_in is captured into rdata on the edge that leaves DATA.
- ACK (1 cycle): ack[winner]=1, En=0, ad_oe=0. Then go to IDLE.
- Arbitration when both ports request in IDLE: round-robin. The port not served last wins. After reset, port 0 wins.
- req and rw are ignored outside IDLE. Request fields are latched on entry to ADDR, so changes mid-cycle have no effect.
- If req drops mid-transaction, the cycle still completes and ack still pulses.
- If req is still high in the IDLE state after ACK, it is treated as a new request.
- Reset values: state IDLE, ack=0, grant=0, rdata=0, ALE=0, En=0, Rw=1, ad_out=0, ad_oe=0, round-robin pointer favours port 0.
- Reset asserted mid-transaction: all outputs take reset values immediately. The in-flight cycle is dropped with no ack.

## Timing
- All outputs are registered and decoded from state. There are no combinational paths from req to the bus.
- Edge E0 samples req in IDLE.
- ADDR runs during the cycle after E0.
- DATA occupies the next 1+WAIT_CYCLES cycles.
- ACK is the following cycle.
- Request-to-ack latency is 3+WAIT_CYCLES cycles. For example, with WAIT_CYCLES=1, ack is high in the 4th cycle after E0.
- Minimum period between grants is 4+WAIT_CYCLES cycles, because of the mandatory IDLE cycle.
- When both ports request continuously, grants strictly alternate.

## Configuration
- MEM_ARB_RR_EN
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority, port 0 always wins; the round-robin pointer is removed. Port 1 can starve while port 0 requests back-to-back.

## Structure
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, ADDR, DATA, ACK)
  - port index constants PORT_CPU=0 and PORT_LDR=1
  - the read/write encoding constants
- One sub-module: mem_arb_pick, the 2-way picker. It takes req and the last-served pointer and returns a one-hot winner. Under fixed priority it reduces to port 0 first.

## Test plan
- Port 0 read, addr=0x3C, ad_in=0xA5, WAIT_CYCLES=1 -> ALE for 1 cycle with ad_out=0x3C, En for 2 cycles with ad_oe=0, ack[0] in cycle 4, rdata=0xA5.
- Port 1 write, addr=0x10, wdata=0x7E -> ADDR drives 0x10, DATA drives 0x7E with Rw=0 and ad_oe=1, then ack[1] and grant returns to 0.
- Both req held high for 4 transactions -> grant order 0,1,0,1 with MEM_ARB_RR_EN defined; 0,0,0,0 with it undefined.
- rst pulsed during DATA of a write -> En, ad_oe and grant drop at once, no ack, next request starts cleanly from IDLE with port 0 priority.
- addr0 changed from 0x20 to 0x55 during DATA -> bus and transaction unaffected, address 0x20 used.
- WAIT_CYCLES=0 read -> ack in cycle 3 after E0, En high for exactly 1 cycle.
